// File: rtl/huff_bit_packer_pkg.sv
// Shared Huffman definitions: codeword
// field layout, output width, packer FSM.
package huff_bit_packer_pkg;

  localparam int CW_LEN_MSB = 35;
  localparam int CW_LEN_LSB = 31;
  localparam int CW_CODE_W  = 31;
  localparam int OUT_W      = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/huff_bit_align.sv
// Left-aligned insert of an L-bit code
// directly below `off` valid bits.
module huff_bit_align
  import huff_bit_packer_pkg::*;
(
  input  logic [62:0]          vec,
  input  logic [5:0]           off,
  input  logic [4:0]           len,
  input  logic [CW_CODE_W-1:0] code,
  output logic [62:0]          res
);

  logic [62:0] mask;
  logic [62:0] ext;
  logic [6:0]  sh;

  // mask the code to len bits, shift it under the valid bits
  always_comb begin
    mask = (63'd1 << len) - 63'd1;
    ext  = {{(63-CW_CODE_W){1'b0}}, code} & mask;
    sh   = 7'd63 - {1'b0, off} - {2'b0, len};
    res  = vec | (ext << sh);
  end

endmodule

// File: rtl/huff_bit_packer.sv
// Packs variable-length Huffman codes
// MSB-first into 32-bit output words.
module huff_bit_packer #(
  parameter int OUT_W = 32,
  parameter int BUF_W = 63
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [35:0]      cw_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [5:0]       out_bits,
  output logic             flush_done,
  output logic             busy
);
  import huff_bit_packer_pkg::*;

  state_t           state_q;
  state_t           state_nx;
  logic [BUF_W-1:0] bits_q;
  logic [BUF_W-1:0] bits_sh;
  logic [BUF_W-1:0] bits_ins;
  logic [5:0]       fill_q;
  logic [5:0]       fill_sh;
  logic [5:0]       fill_nx;
  logic [4:0]       len_in;
  logic [OUT_W-1:0] tail_mask;
  logic             slot_free;
  logic             drain;
  logic             tail;
  logic             acc;

  // handshake, drain-then-append datapath
  always_comb begin
    slot_free = !out_valid || out_ready;
    drain     = (fill_q >= 6'd32) && slot_free;
    tail      = (state_q == FLUSH) && (fill_q != 6'd0)
                && (fill_q < 6'd32) && slot_free;
    cw_ready  = (state_q == RUN) && (fill_q <= 6'd32);
    acc       = cw_valid && cw_ready;
    len_in    = acc ? cw_data[CW_LEN_MSB:CW_LEN_LSB] : 5'd0;
    bits_sh   = drain ? {bits_q[BUF_W-OUT_W-1:0], {OUT_W{1'b0}}}
                      : bits_q;
    fill_sh   = drain ? fill_q - 6'd32 : fill_q;
    fill_nx   = fill_sh + {1'b0, len_in};
    tail_mask = ~({OUT_W{1'b1}} >> fill_q[4:0]);
    busy      = (state_q != RUN) || (fill_q != 6'd0);
  end

  huff_bit_align u_align (
    .vec  (bits_sh),
    .off  (fill_sh),
    .len  (len_in),
    .code (cw_data[CW_CODE_W-1:0]),
    .res  (bits_ins)
  );

  // block sequencing: run, drain tail, report done
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      RUN:     if (flush) state_nx = FLUSH;
      FLUSH:   if (tail || fill_q == 6'd0) state_nx = DONE;
      DONE:    if (slot_free) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // state, bit buffer and fill level
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= RUN;
      bits_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_nx;
      bits_q  <= tail ? '0 : bits_ins;
      fill_q  <= tail ? 6'd0 : fill_nx;
    end
  end

  // output word slot and done pulse
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_bits   <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state_q == DONE) && slot_free;
      if (drain) begin
        out_valid <= 1'b1;
        out_data  <= bits_q[BUF_W-1 -: OUT_W];
        out_bits  <= 6'd32;
        out_last  <= (state_q == FLUSH) && (fill_q == 6'd32);
      end else if (tail) begin
        out_valid <= 1'b1;
        out_data  <= bits_q[BUF_W-1 -: OUT_W] & tail_mask;
        out_bits  <= fill_q;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Bench for huff_bit_packer: random code
// streams against a bit-queue model.
module tb_huff_bit_packer;

  logic        clk;
  logic        rstN;
  logic        cw_valid;
  logic        cw_ready;
  logic [35:0] cw_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [5:0]  out_bits;
  logic        flush_done;
  logic        busy;

  int          ncmp;
  int          nerr;
  int          done_cnt;
  bit          rdy_rand;
  logic [35:0] sent[$];
  logic [38:0] exp_q[$];
  logic [38:0] got_q[$];

  huff_bit_packer dut (
    .clk        (clk),
    .rstN       (rstN),
    .cw_valid   (cw_valid),
    .cw_ready   (cw_ready),
    .cw_data    (cw_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_bits   (out_bits),
    .flush_done (flush_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // random downstream readiness
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // collect handshaken words and done pulses
  always @(negedge clk) begin
    if (rstN) begin
      if (out_valid && out_ready)
        got_q.push_back({out_last, out_bits, out_data});
      if (flush_done) done_cnt++;
    end
  end

  // fill must never pass 63 after an append
  always @(posedge clk) begin
    if (rstN && cw_valid && cw_ready)
      assert ({1'b0, dut.fill_q} + {2'b0, cw_data[35:31]}
              <= 7'd63)
      else $error("FAIL fill_overflow fill=%0d",
                  dut.fill_q);
  end

  // reference: flat bit stream cut into words
  function automatic void build_exp();
    bit s[$];
    exp_q = {};
    foreach (sent[i]) begin
      int l;
      l = int'(sent[i][35:31]);
      for (int b = l - 1; b >= 0; b--)
        s.push_back(sent[i][b]);
    end
    while (s.size() > 0) begin
      logic [31:0] w;
      int n;
      w = '0;
      n = (s.size() >= 32) ? 32 : s.size();
      for (int b = 0; b < n; b++) w[31-b] = s.pop_front();
      exp_q.push_back({(s.size() == 0), 6'(n), w});
    end
  endfunction

  task automatic start_block();
    sent = {};
    got_q = {};
    done_cnt = 0;
  endtask

  task automatic put_cw(input logic [4:0] l,
                        input logic [30:0] c,
                        input bit fl);
    int n;
    n = 0;
    while (!cw_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cw_ready) begin
      ncmp++;
      nerr++;
      $display("FAIL cw_ready_timeout got 0 want 1");
    end
    cw_valid = 1'b1;
    cw_data  = {l, c};
    flush    = fl;
    sent.push_back({l, c});
    @(posedge clk);
    #1;
    cw_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    ncmp++;
    if (done_cnt == 0) begin
      nerr++;
      $display("FAIL flush_done_timeout got 0 want 1");
    end
  endtask

  task automatic test_reset();
    ncmp += 7;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL rst_valid got %b want 0", out_valid);
    end
    if (out_data !== 32'h0) begin
      nerr++; $display("FAIL rst_data got %h want 0", out_data);
    end
    if (out_last !== 1'b0) begin
      nerr++; $display("FAIL rst_last got %b want 0", out_last);
    end
    if (out_bits !== 6'd0) begin
      nerr++; $display("FAIL rst_bits got %0d want 0", out_bits);
    end
    if (flush_done !== 1'b0) begin
      nerr++; $display("FAIL rst_done got %b want 0", flush_done);
    end
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL rst_busy got %b want 0", busy);
    end
    if (cw_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_ready got %b want 1", cw_ready);
    end
  endtask

  task automatic test_basic();
    start_block();
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) put_cw(5'd4, 31'hA, i == 7);
    wait_done();
    ncmp += 3;
    if (got_q.size() != 1) begin
      nerr++;
      $display("FAIL basic_count got %0d want 1", got_q.size());
    end
    if (got_q.size() < 1 ||
        got_q[0] !== {1'b1, 6'd32, 32'hAAAA_AAAA}) begin
      nerr++;
      $display("FAIL basic_word got %p want last/32/aaaaaaaa",
               got_q);
    end
    if (flush_done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_pulse got done=%b busy=%b want 0 0",
               flush_done, busy);
    end
  endtask

  task automatic test_two_words();
    start_block();
    out_ready = 1'b1;
    put_cw(5'd31, 31'h7FFF_FFFF, 1'b0);
    put_cw(5'd2, 31'h1, 1'b1);
    wait_done();
    ncmp += 3;
    if (got_q.size() != 2) begin
      nerr++;
      $display("FAIL two_count got %0d want 2", got_q.size());
    end
    if (got_q.size() < 1 ||
        got_q[0] !== {1'b0, 6'd32, 32'hFFFF_FFFE}) begin
      nerr++;
      $display("FAIL two_w0 got %p want 0/32/fffffffe", got_q);
    end
    if (got_q.size() < 2 ||
        got_q[1] !== {1'b1, 6'd1, 32'h8000_0000}) begin
      nerr++;
      $display("FAIL two_w1 got %p want 1/1/80000000", got_q);
    end
  endtask

  task automatic test_empty_flush();
    start_block();
    out_ready = 1'b1;
    put_cw(5'd0, 31'h0, 1'b1);
    ncmp += 5;
    if (flush_done !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL empty_c1 got done=%b busy=%b want 0 1",
               flush_done, busy);
    end
    @(posedge clk);
    #1;
    if (flush_done !== 1'b0) begin
      nerr++;
      $display("FAIL empty_c2 got done=%b want 0", flush_done);
    end
    @(posedge clk);
    #1;
    if (flush_done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL empty_c3 got done=%b busy=%b want 1 0",
               flush_done, busy);
    end
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL empty_valid got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    if (flush_done !== 1'b0 || got_q.size() != 0) begin
      nerr++;
      $display("FAIL empty_c4 got done=%b words=%0d want 0 0",
               flush_done, got_q.size());
    end
  endtask

  task automatic test_backpressure();
    int          stalls;
    bit          have;
    logic [31:0] first;
    start_block();
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    stalls    = 0;
    have      = 1'b0;
    first     = '0;
    for (int c = 0; c < 20; c++) begin
      cw_valid = 1'b1;
      cw_data  = {5'd31, 31'($urandom)};
      @(negedge clk);
      if (cw_ready) sent.push_back(cw_data);
      else stalls++;
      if (out_valid && !have) begin
        first = out_data;
        have  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cw_valid = 1'b0;
    ncmp += 3;
    if (stalls == 0 || cw_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_ready got stalls=%0d ready=%b want >0 0",
               stalls, cw_ready);
    end
    if (out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_valid got %b want 1", out_valid);
    end
    if (out_data !== first) begin
      nerr++;
      $display("FAIL bp_stable got %h want %h", out_data, first);
    end
    rdy_rand = 1'b1;
    put_cw(5'($urandom_range(1, 31)), 31'($urandom), 1'b1);
    wait_done();
    build_exp();
    ncmp++;
    if (got_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL bp_count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== exp_q[i]) begin
        nerr++;
        $display("FAIL bp_word%0d got %h want %h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [35:0] ref_list[$];
    start_block();
    rdy_rand = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 1) == 1)
        put_cw(5'd0, 31'($urandom), 1'b0);
      put_cw(5'd5, 31'h15 | (31'($urandom) << 5), i == 14);
      ref_list.push_back({5'd5, 31'h15});
    end
    wait_done();
    sent = ref_list;
    build_exp();
    ncmp++;
    if (got_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL zl_count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== exp_q[i]) begin
        nerr++;
        $display("FAIL zl_word%0d got %h want %h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 6; blk++) begin
      int n;
      start_block();
      rdy_rand = 1'b1;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1)
          put_cw(5'($urandom_range(1, 31)), 31'($urandom), 1'b1);
        else
          put_cw(5'($urandom_range(0, 31)), 31'($urandom), 1'b0);
      end
      wait_done();
      build_exp();
      ncmp++;
      if (got_q.size() != exp_q.size()) begin
        nerr++;
        $display("FAIL rnd%0d_count got %0d want %0d",
                 blk, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        ncmp++;
        if (got_q[i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL rnd%0d_word%0d got %h want %h",
                   blk, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    start_block();
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    put_cw(5'd20, 31'($urandom), 1'b0);
    put_cw(5'd20, 31'($urandom), 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ncmp += 3;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL rmf_pre got valid=%b busy=%b want 1 1",
               out_valid, busy);
    end
    #2;
    rstN = 1'b0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rmf_rst got valid=%b busy=%b want 0 0",
               out_valid, busy);
    end
    if (out_data !== 32'h0 || out_last !== 1'b0) begin
      nerr++;
      $display("FAIL rmf_regs got %h/%b want 0/0",
               out_data, out_last);
    end
    @(posedge clk);
    #3;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    start_block();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      put_cw(5'd4, 31'($urandom), i == 7);
    wait_done();
    build_exp();
    ncmp++;
    if (got_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL rmf_count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      ncmp++;
      if (got_q[i] !== exp_q[i]) begin
        nerr++;
        $display("FAIL rmf_word%0d got %h want %h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    ncmp      = 0;
    nerr      = 0;
    done_cnt  = 0;
    rdy_rand  = 1'b0;
    rstN      = 1'b0;
    cw_valid  = 1'b0;
    cw_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #22;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_two_words();
    test_empty_flush();
    test_backpressure();
    test_zero_len();
    test_random();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/huff_bit_packer.md
Name: huff_bit_packer

Overview:
- Downstream consumer of the 36-bit registered Huffman codeword bus.
- Concatenates variable-length codes MSB-first into a 63-bit bit buffer.
- Emits packed 32-bit words to the output stream with valid/ready backpressure.
- On a flush request, zero-pads and emits the final partial word with a valid-bit count.

Parameters:
- OUT_W, 32, output word width; fixed, the only supported value.
- BUF_W, 63, bit buffer width; must equal OUT_W + 31.

Ports:
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous active-low reset
- cw_valid  in  1  codeword present on cw_data
- cw_ready  out  1  packer accepts codeword this cycle
- cw_data  in  36  [35:31] code length L (0..31); [30:0] code, right-aligned, bits above L ignored
- flush  in  1  single-cycle end-of-block request
- out_valid  out  1  out_data holds a word
- out_ready  in  1  downstream takes the word
- out_data  out  32  packed bits, first code bit at bit 31
- out_last  out  1  word is the final word of the block
- out_bits  out  6  valid bits in out_data (32, or 1..32 on the last word)
- flush_done  out  1  one-cycle pulse: block fully drained
- busy  out  1  state != RUN or fill != 0

Behaviour:
- Reset (async, rstN low):
  - state = RUN; fill = 0; buffer = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_bits = 0, flush_done = 0.
  - Reset mid-block discards all buffered bits; there is no partial emission.
- Bit buffer:
  - buf[62:0] holds valid bits MSB-aligned in buf[62 -: fill].
  - fill is a 6-bit register, range 0..63.
- Output slot:
  - slot_free = !out_valid || out_ready.
  - The out_* registers hold stable while out_valid && !out_ready.
- Drain (every edge):
  - Condition: fill >= 32 && slot_free.
  - Load out_data = buf[62:31], out_bits = 32.
  - Shift buf left by 32; fill -= 32.
  - out_valid drops only when out_ready is high and no new word loads on that edge.
- Accept:
  - cw_ready = (state == RUN) && (fill <= 32), decoded from registered state only.
  - On cw_valid && cw_ready, insert the low L bits of the code directly below the current valid bits; fill += L.
  - A codeword with L = 0 is accepted and changes nothing.
- Simultaneous drain and accept: the drain shift applies first, then the new code is appended at the post-drain fill position. fill_next = fill - 32 + L.
- Latency: a code accepted at edge N can appear in out_data no earlier than edge N+1.
- States:
  - RUN: on flush, go to FLUSH (any codeword accepted on the same edge is included).
  - FLUSH: cw_ready = 0. Drains proceed as above. out_last = 1 on the drain where fill == 32.
    - fill in 1..31 with slot_free: load buf[62:31] with the invalid tail zeroed, out_bits = fill, out_last = 1, fill = 0, go to DONE.
    - fill == 0 and no last word pending: go to DONE. An empty block produces no out_last.
  - DONE: wait for !out_valid or (out_valid && out_ready); assert flush_done for one cycle; return to RUN.
- flush asserted outside RUN is ignored.
- Invariant: fill never exceeds 63. Any overflow is a design bug; the bench checks for it with an assertion.

Decomposition:
- Shared huffman package holds:
  - Codeword field constants: CW_LEN_MSB = 35, CW_LEN_LSB = 31, CW_CODE_W = 31.
  - OUT_W and the state encoding (RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2).
- One sub-module, huff_bit_align: combinational left-aligned insert of an L-bit code at a fill offset into a 63-bit vector. The packer keeps all registers and the FSM.

Test Plan:
- Eight codes L = 4, value 4'hA; flush; out_ready = 1 -> one word 32'hAAAA_AAAA, out_last = 1, out_bits = 32, then flush_done pulse.
- Codes L = 31 all-ones, then L = 1 value 0; flush -> words 32'hFFFF_FFFE, then 32'h0000_0000 with out_bits = 0?? Not legal; instead use L = 31 ones, L = 2 value 2'b01; flush -> 32'hFFFF_FFFE with out_bits = 32, then 32'h8000_0000 with out_last = 1, out_bits = 1.
- out_ready held low for 20 cycles under continuous L = 31 input -> cw_ready deasserts once fill > 32; out_data stable; no bits lost after release (reference-model compare).
- Flush with an empty buffer -> no out_valid, flush_done pulses 2 cycles later, busy = 0.
- L = 0 codewords interleaved with L = 5 value 5'b10101 -> output identical to the stream without the zero-length codes.
- rstN asserted mid-FLUSH with out_valid high -> out_valid = 0 and fill = 0 immediately; after release, a new block packs correctly from bit 31.
